apb_bridge_fsm: RTL and testbench

- Sequencing controller for the AHB-to-APB bridge.
- Consumes the AHB slave interface's pipelined outputs (valid, Haddr/Haddr1/Haddr2, Hwrite/Hwritereg) plus current write data.
- Drives the APB master signals (Pselx, Penable, Pwrite, Paddr, Pwdata) and AHB Hreadyout.
- Handles single and back-to-back (pipelined) reads/writes across three APB slaves.

---
 rtl/apb_bridge_fsm.sv | 161 ++++++++++++++++
 tb/tb_apb_bridge_fsm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge_fsm.sv
// rtl/apb_bridge_fsm.sv - AHB-to-APB bridge sequencing FSM with registered APB outputs
// Optional macro APB_PREADY_EN: enable phases hold while Pready is low.
module apb_bridge_fsm #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              valid,
  input  logic              Hwrite,
  input  logic              Hwritereg,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [ADDR_W-1:0] Haddr1,
  input  logic [ADDR_W-1:0] Haddr2,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic              Pready,
  output logic [2:0]        Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Hreadyout
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WWAIT, ST_READ, ST_WRITE,
    ST_WRITEP, ST_RENABLE, ST_WENABLE, ST_WENABLEP
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          pselx_q, pselx_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                hready_q, hready_d;
  logic                stall;

  // Three 64 MB slave windows starting at 0x8000_0000.
  function automatic logic [2:0] sel_decode(input logic [ADDR_W-1:0] a);
    case (a[31:26])
      6'h20:   return 3'b001;
      6'h21:   return 3'b010;
      6'h22:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

`ifdef APB_PREADY_EN
  assign stall = ((state_q == ST_RENABLE) || (state_q == ST_WENABLE) ||
                  (state_q == ST_WENABLEP)) && !Pready;
`else
  logic unused_pready;
  assign stall         = 1'b0;
  assign unused_pready = Pready;
`endif

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= ST_IDLE;
      pselx_q   <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      hready_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      pselx_q   <= pselx_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      hready_q  <= hready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!stall) begin
      case (state_q)
        ST_IDLE, ST_RENABLE, ST_WENABLE: begin
          if (valid && !Hwrite)     state_d = ST_READ;
          else if (valid && Hwrite) state_d = ST_WWAIT;
          else                      state_d = ST_IDLE;
        end
        ST_WWAIT:    state_d = valid ? ST_WRITEP : ST_WRITE;
        ST_READ:     state_d = ST_RENABLE;
        ST_WRITE:    state_d = valid ? ST_WENABLEP : ST_WENABLE;
        ST_WRITEP:   state_d = ST_WENABLEP;
        ST_WENABLEP: begin
          if (Hwritereg) state_d = valid ? ST_WRITEP : ST_WRITE;
          else           state_d = ST_READ;
        end
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pselx_d   = pselx_q;
    penable_d = 1'b0;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    hready_d  = 1'b1;
    if (stall) begin
      penable_d = 1'b1;
      hready_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RENABLE, ST_WENABLE: begin
          if (valid && !Hwrite) begin
            paddr_d  = Haddr;
            pwrite_d = 1'b0;
            pselx_d  = sel_decode(Haddr);
            hready_d = 1'b0;
          end else begin
            pselx_d  = 3'b000;
          end
        end
        ST_WWAIT: begin
          paddr_d  = Haddr1;
          pwdata_d = Hwdata;
          pwrite_d = 1'b1;
          pselx_d  = sel_decode(Haddr1);
          hready_d = !valid;
        end
        ST_READ, ST_WRITE, ST_WRITEP: begin
          penable_d = 1'b1;
        end
        ST_WENABLEP: begin
          // Pipelined write: the pending address is two address phases old.
          if (Hwritereg) begin
            paddr_d  = Haddr2;
            pwdata_d = Hwdata;
            pwrite_d = 1'b1;
            pselx_d  = sel_decode(Haddr2);
            hready_d = !valid;
          end else begin
            paddr_d  = Haddr;
            pwrite_d = 1'b0;
            pselx_d  = sel_decode(Haddr);
            hready_d = 1'b0;
          end
        end
        default: begin
          pselx_d = 3'b000;
        end
      endcase
    end
  end

  assign Pselx     = pselx_q;
  assign Penable   = penable_q;
  assign Pwrite    = pwrite_q;
  assign Paddr     = paddr_q;
  assign Pwdata    = pwdata_q;
  assign Hreadyout = hready_q;

endmodule

// File: tb/tb_apb_bridge_fsm.sv
// tb/tb_apb_bridge_fsm.sv - self-checking bench for apb_bridge_fsm
module tb_apb_bridge_fsm;

  logic        Hclk = 1'b0;
  logic        Hresetn = 1'b0;
  logic        valid = 1'b0, Hwrite = 1'b0, Hwritereg = 1'b0, Pready = 1'b1;
  logic [31:0] Haddr = '0, Haddr1 = '0, Haddr2 = '0, Hwdata = '0;
  logic [2:0]  Pselx;
  logic        Penable, Pwrite, Hreadyout;
  logic [31:0] Paddr, Pwdata;

  apb_bridge_fsm #(.ADDR_W(32), .DATA_W(32)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .valid(valid), .Hwrite(Hwrite),
    .Hwritereg(Hwritereg), .Haddr(Haddr), .Haddr1(Haddr1), .Haddr2(Haddr2),
    .Hwdata(Hwdata), .Pready(Pready), .Pselx(Pselx), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata), .Hreadyout(Hreadyout)
  );

  always #5 Hclk = ~Hclk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } txn_t;

  txn_t        pend_q[$];
  txn_t        exp_q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] cur_data = '0;
  logic        prev_en = 1'b0, prev_wr = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  logic [2:0]  prev_sel = '0;

  function automatic logic [2:0] ref_sel(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h8000_0000;
    if (a < 32'h8000_0000 || off >= 32'h0C00_0000) return 3'b000;
    return 3'b001 << (off / 32'h0400_0000);
  endfunction

  function automatic logic [31:0] rand_addr();
    int region;
    region = ($urandom_range(0, 9) < 9) ? $urandom_range(0, 2) : 3;
    return 32'h8000_0000 + 32'(region) * 32'h0400_0000 + ($urandom & 32'h03FF_FFFC);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    txn_t t;
    if (Penable) begin
      chk("apb_setup_then_enable_stable",
          {prev_en, Paddr, Pwrite, Pselx, (Pwrite ? Pwdata : 32'h0)},
          {1'b0, prev_addr, prev_wr, prev_sel, (prev_wr ? prev_wdata : 32'h0)});
      if (exp_q.size() == 0) begin
        chk("apb_unexpected_access", 1, 0);
      end else begin
        t = exp_q.pop_front();
        chk("apb_transfer", {Paddr, Pwrite, Pselx, (Pwrite ? Pwdata : 32'h0)},
            {t.addr, t.wr, ref_sel(t.addr), (t.wr ? t.data : 32'h0)});
      end
    end
    prev_en = Penable; prev_wr = Pwrite; prev_addr = Paddr;
    prev_wdata = Pwdata; prev_sel = Pselx;
  endtask

  // AHB master issues the next queued transfer whenever the bridge is ready;
  // the slave-side pipeline registers are emulated just after the edge.
  task automatic step();
    txn_t t;
    if (Hreadyout && pend_q.size() > 0) begin
      t = pend_q.pop_front();
      valid = 1'b1; Haddr = t.addr; Hwrite = t.wr; cur_data = t.data;
      exp_q.push_back(t);
    end else begin
      valid = 1'b0;
    end
    @(posedge Hclk);
    #1;
    Haddr2 = Haddr1; Haddr1 = Haddr; Hwritereg = Hwrite;
    if (valid && Hwrite) Hwdata = cur_data;
    valid = 1'b0;
    monitor();
  endtask

  task automatic drain(input int idle_after);
    int guard;
    guard = 0;
    while (pend_q.size() > 0 && guard < 60) begin
      step();
      guard++;
    end
    if (pend_q.size() > 0) begin
      chk("drain_timeout", pend_q.size(), 0);
      pend_q.delete();
    end
    repeat (idle_after) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nr, nw;
    repeat (2) @(posedge Hclk);
    #1;
    chk("reset_outputs", {Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout},
        {3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1});
    @(negedge Hclk);
    Hresetn = 1'b1;

    // Single read
    pend_q.push_back('{32'h8000_0010, 1'b0, 32'h0});
    step();
    chk("rd_setup", {Pselx, Paddr, Pwrite, Penable, Hreadyout},
        {3'b001, 32'h8000_0010, 1'b0, 1'b0, 1'b0});
    step();
    chk("rd_enable", {Pselx, Paddr, Pwrite, Penable, Hreadyout},
        {3'b001, 32'h8000_0010, 1'b0, 1'b1, 1'b1});
    step();
    chk("rd_done", {Pselx, Penable, Hreadyout}, {3'b000, 1'b0, 1'b1});

    // Single write
    pend_q.push_back('{32'h8400_0004, 1'b1, 32'hA5A5_A5A5});
    step();
    chk("wr_wait", {Pselx, Penable, Hreadyout}, {3'b000, 1'b0, 1'b1});
    step();
    chk("wr_setup", {Pselx, Paddr, Pwrite, Pwdata, Penable, Hreadyout},
        {3'b010, 32'h8400_0004, 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b1});
    step();
    chk("wr_enable", {Pselx, Paddr, Pwrite, Pwdata, Penable, Hreadyout},
        {3'b010, 32'h8400_0004, 1'b1, 32'hA5A5_A5A5, 1'b1, 1'b1});
    step();
    chk("wr_done", {Pselx, Penable}, {3'b000, 1'b0});

    // Back-to-back writes
    pend_q.push_back('{32'h8800_0000, 1'b1, 32'h1111_1111});
    pend_q.push_back('{32'h8800_0004, 1'b1, 32'h2222_2222});
    step();
    step();
    chk("b2b_setup1", {Pselx, Paddr, Pwdata, Pwrite, Penable, Hreadyout},
        {3'b100, 32'h8800_0000, 32'h1111_1111, 1'b1, 1'b0, 1'b0});
    step();
    chk("b2b_enable1", {Pselx, Paddr, Penable, Hreadyout},
        {3'b100, 32'h8800_0000, 1'b1, 1'b1});
    step();
    chk("b2b_setup2", {Pselx, Paddr, Pwdata, Pwrite, Penable, Hreadyout},
        {3'b100, 32'h8800_0004, 32'h2222_2222, 1'b1, 1'b0, 1'b1});
    step();
    chk("b2b_enable2", {Pselx, Paddr, Penable}, {3'b100, 32'h8800_0004, 1'b1});
    step();
    chk("b2b_done", {Pselx, Penable}, {3'b000, 1'b0});

    // Write followed by read
    pend_q.push_back('{32'h8400_0008, 1'b1, 32'h3C3C_3C3C});
    pend_q.push_back('{32'h8000_0000, 1'b0, 32'h0});
    step();
    step();
    chk("wr_rd_write_setup", {Pselx, Paddr, Pwrite, Pwdata, Penable, Hreadyout},
        {3'b010, 32'h8400_0008, 1'b1, 32'h3C3C_3C3C, 1'b0, 1'b0});
    step();
    step();
    chk("wr_rd_read_setup", {Pselx, Paddr, Pwrite, Penable, Hreadyout},
        {3'b001, 32'h8000_0000, 1'b0, 1'b0, 1'b0});
    step();
    chk("wr_rd_read_enable", {Pselx, Paddr, Pwrite, Penable, Hreadyout},
        {3'b001, 32'h8000_0000, 1'b0, 1'b1, 1'b1});
    drain(3);

    // Window boundaries and an out-of-map access
    pend_q.push_back('{32'h83FF_FFFC, 1'b0, 32'h0});
    pend_q.push_back('{32'h8400_0000, 1'b1, 32'h0BAD_CAFE});
    pend_q.push_back('{32'h8BFF_FFFC, 1'b1, 32'h1234_5678});
    drain(5);
    pend_q.push_back('{32'h8C00_0000, 1'b0, 32'h0});
    drain(5);
    pend_q.push_back('{32'h7FFF_FFFC, 1'b1, 32'hDEAD_BEEF});
    drain(5);

    // Random bursts: reads, then a write chain, optionally closed by one read
    for (int b = 0; b < 40; b++) begin
      nr = $urandom_range(0, 2);
      nw = $urandom_range(0, 3);
      if (nr + nw == 0) nr = 1;
      for (int i = 0; i < nr; i++) pend_q.push_back('{rand_addr(), 1'b0, 32'h0});
      for (int i = 0; i < nw; i++) pend_q.push_back('{rand_addr(), 1'b1, $urandom});
      if (nw > 0 && $urandom_range(0, 1) == 1)
        pend_q.push_back('{rand_addr(), 1'b0, 32'h0});
      drain(5);
    end
    chk("all_transfers_completed", exp_q.size(), 0);

    // Asynchronous reset in the middle of an access
    pend_q.push_back('{32'h8000_0010, 1'b0, 32'h0});
    step();
    #3;
    Hresetn = 1'b0;
    #1;
    chk("reset_mid_access", {Pselx, Penable, Hreadyout, Paddr},
        {3'b000, 1'b0, 1'b1, 32'h0});
    exp_q.delete();
    Haddr = '0; Haddr1 = '0; Haddr2 = '0; Hwrite = 1'b0; Hwritereg = 1'b0;
    prev_en = 1'b0; prev_wr = 1'b0; prev_addr = '0; prev_wdata = '0; prev_sel = '0;
    @(negedge Hclk);
    Hresetn = 1'b1;
    step();
    chk("reset_no_partial_cycle", {Pselx, Penable}, {3'b000, 1'b0});
    pend_q.push_back('{32'h8800_0010, 1'b1, 32'h5A5A_0F0F});
    drain(5);
    chk("post_reset_transfers_completed", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
